// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator output path.
//   tx_state_t  : tx_sequencer FSM states
//   MODE_VECTOR : frame is read from result memory
//   MODE_SCALAR : frame is the two bytes of scalar_result
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    SEND,
    WAIT_TX,
    CSUM,
    FINISH
  } tx_state_t;

  localparam logic MODE_VECTOR = 1'b0;
  localparam logic MODE_SCALAR = 1'b1;

endpackage

// File: rtl/tx_sequencer.sv
// tx_sequencer: streams one result frame, byte by byte, into uart_tx.
// A vector frame is NBytes bytes read from result memory in ascending address
// order; a scalar frame is scalar_result MSB then LSB. Each byte is presented on
// tx_output with a one-cycle send pulse and held until the UART reports tx_flag.
// A one-cycle done pulse marks a completed (non-aborted) frame.
//
// Optional feature: define TX_CHECKSUM_EN to append a two's-complement checksum
// byte (8-bit sum of all data bytes, negated) after the data bytes.
//
// Ports:
//   clk, reset     clock; asynchronous active-low reset
//   start          1-cycle pulse, begins a frame when idle
//   mode           0 vector / 1 scalar, sampled with start
//   abort          level, ends the frame at the next tx_flag
//   scalar_result  16-bit scalar value, captured with start
//   mem_data       result memory data, valid the cycle after mem_rd_en
//   tx_flag        UART byte-done pulse
//   mem_rd_en      result memory read strobe
//   mem_addr       result memory read address
//   send           1-cycle pulse to UART Tx_DV
//   tx_output      byte to UART
//   busy           high while a frame is in progress
//   done           1-cycle frame-complete pulse
module tx_sequencer #(
  parameter int NBytes = 1024,
  parameter int ADDR_W = $clog2(NBytes)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic [15:0]       scalar_result,
  input  logic [7:0]        mem_data,
  input  logic              tx_flag,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              send,
  output logic [7:0]        tx_output,
  output logic              busy,
  output logic              done
);

  import accel_pkg::*;

  localparam logic [ADDR_W:0] VEC_LAST = (ADDR_W + 1)'(NBytes - 1);
  localparam logic [ADDR_W:0] SCL_LAST = (ADDR_W + 1)'(1);

  tx_state_t       state;
  tx_state_t       state_next;
  logic [ADDR_W:0] cnt;
  logic            mode_q;
  logic [15:0]     scalar_q;
  logic [7:0]      byte_in;
  logic            is_last;

`ifdef TX_CHECKSUM_EN
  logic [7:0]      sum;
  // Set once the checksum byte has been loaded, so the following tx_flag ends the frame.
  logic            csum_phase;
`endif

  assign is_last  = (cnt == ((mode_q == MODE_SCALAR) ? SCL_LAST : VEC_LAST));
  assign byte_in  = (mode_q == MODE_SCALAR)
                    ? ((cnt == '0) ? scalar_q[15:8] : scalar_q[7:0])
                    : mem_data;
  assign mem_addr = cnt[ADDR_W-1:0];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    send       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        mem_rd_en  = (mode_q == MODE_VECTOR);
        state_next = WAIT_RD;
      end
      WAIT_RD: begin
        state_next = SEND;
      end
      SEND: begin
        send       = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_flag) begin
          if (abort) begin
            state_next = IDLE;
          end else begin
`ifdef TX_CHECKSUM_EN
            if (csum_phase)   state_next = FINISH;
            else if (is_last) state_next = CSUM;
            else              state_next = FETCH;
`else
            if (is_last) state_next = FINISH;
            else         state_next = FETCH;
`endif
          end
        end
      end
      CSUM: begin
        state_next = SEND;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      mode_q     <= MODE_VECTOR;
      scalar_q   <= '0;
      tx_output  <= '0;
`ifdef TX_CHECKSUM_EN
      sum        <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            scalar_q   <= scalar_result;
            cnt        <= '0;
`ifdef TX_CHECKSUM_EN
            sum        <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end
        WAIT_RD: begin
          tx_output <= byte_in;
`ifdef TX_CHECKSUM_EN
          sum       <= sum + byte_in;
`endif
        end
        WAIT_TX: begin
`ifdef TX_CHECKSUM_EN
          if (tx_flag && !abort && !is_last && !csum_phase) cnt <= cnt + 1'b1;
`else
          if (tx_flag && !abort && !is_last) cnt <= cnt + 1'b1;
`endif
        end
`ifdef TX_CHECKSUM_EN
        CSUM: begin
          tx_output  <= ~sum + 8'd1;
          csum_phase <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
